px_bus_iface: RTL
=================

Name: px_bus_iface

Overview:
- CPU-side system bus interface stage directly downstream of the P-X state control unit.
- Takes the P-X bus request (zg) and driver strobes (dr_, dw_), and grants the bus (zw1_).
- Runs one memory transfer on a simple request/ack memory port.
- Returns the bus answer lines rok_, ren_ and rpe_ that P-X uses for its OK/alarm/parity logic.
- Generates no timeout alarm itself: P-X owns the alarm delay. This block only abandons a stuck transfer.

Parameters:
- TIMEOUT_CYCLES, 8'd200: REQ cycles without mem_ack before the transfer is abandoned.
- RESP_CYCLES, 3'd3: width of the rok_/ren_/rpe_ answer pulse, in __clk cycles (minimum 1).

Ports:
- __clk  in  1  system clock.
- clo  in  1  general clear. Synchronous, active-high.
- zg  in  1  bus request from P-X.
- zw1_  out  1  bus granted to CPU module 1. Active-low.
- dr_  in  1  read driver strobe. Active-low.
- dw_  in  1  write driver strobe. Active-low.
- nb  in  4  memory block number.
- ad  in  16  address word.
- dt_o  in  16  write data from CPU.
- dt_i  out  16  read data to CPU.
- rok_  out  1  transfer OK answer. Active-low.
- ren_  out  1  no-memory answer. Active-low.
- rpe_  out  1  parity error answer. Active-low.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  20  address, formed as {nb, ad}.
- mem_wdata  out  16  write data.
- mem_ack  in  1  memory cycle complete.
- mem_rdata  in  16  read data. Valid with mem_ack.
- mem_perr  in  1  parity error. Valid with mem_ack.
- mem_nomem  in  1  no memory at address. Valid with mem_ack.

Behaviour:
- All logic on posedge __clk.
- clo=1 at any edge, including mid-transfer:
  - state forced to IDLE;
  - zw1_=1, rok_=ren_=rpe_=1;
  - mem_req=0, mem_we=0, counters=0, dt_i=0.
  - A transfer abandoned by clo produces no answer.
- FSM states: IDLE, GRANT, REQ, RESP, RELEASE.
- IDLE:
  - zg=1 moves to GRANT; zw1_ goes 0 on that same edge (1-cycle grant latency).
- GRANT:
  - zw1_=0 throughout.
  - Exactly one of dr_, dw_ low: latch mem_addr={nb,ad}, mem_wdata=dt_o, mem_we=~dw_; go to REQ.
  - Both strobes low: illegal. Stay in GRANT, no memory access.
  - zg=0 with no strobe: go to IDLE, zw1_=1.
- REQ:
  - mem_req=1. The timeout counter increments each cycle.
  - mem_ack=1: deassert mem_req and go to RESP.
    - Read: latch dt_i=mem_rdata.
    - mem_nomem=1: select ren_. Otherwise select rok_.
    - mem_perr=1 on a read: select rpe_ in addition to rok_. On a write, mem_perr is ignored.
  - Counter reaches TIMEOUT_CYCLES with no ack: deassert mem_req, go to RELEASE with no answer.
  - A mem_ack arriving after abandonment is ignored.
- RESP:
  - The selected answer lines are held low for exactly RESP_CYCLES cycles, then go to RELEASE.
  - rok_ and ren_ are never low together.
- RELEASE:
  - Wait until zg=0 and dr_=dw_=1, then go to IDLE; zw1_=1 on that edge.
  - If zg stays high, no new grant is issued until it has dropped.
- Hold rules:
  - dt_i holds its value until the next completed read.
  - mem_addr, mem_wdata and mem_we are stable from entry to REQ until the ack or abandonment.
- Strobes changing during REQ/RESP are ignored. The transfer type is fixed at the GRANT sample.
- Counter widths: the timeout counter is 8-bit and saturates; the response counter is 3-bit. No wrap-around is permitted.

Test Plan:
- Read, ack after 3 cycles:
  - Stimulus: zg=1; then dr_=0, nb=4'h2, ad=16'h1234; mem_ack with mem_rdata=16'hBEEF.
  - Required: zw1_=0 one cycle after zg; mem_req 1 with mem_addr=20'h21234, mem_we=0; rok_ low 3 cycles; dt_i=16'hBEEF; zw1_=1 after zg and dr_ are released.
- Write:
  - Stimulus: dw_=0, dt_o=16'h00FF, mem_ack with mem_perr=1.
  - Required: mem_we=1, mem_wdata=16'h00FF; rok_ low 3 cycles; rpe_ stays 1; dt_i unchanged.
- No memory:
  - Stimulus: read acked with mem_nomem=1.
  - Required: ren_ low 3 cycles; rok_ stays 1.
- Read parity error:
  - Stimulus: read acked with mem_perr=1.
  - Required: rok_ and rpe_ low together for 3 cycles.
- Timeout:
  - Stimulus: read with no mem_ack.
  - Required: mem_req drops after 200 cycles; no answer line ever goes low; a late mem_ack is ignored; IDLE after zg drops.
- Reset mid-REQ, plus illegal strobes:
  - Stimulus: clo=1 during REQ.
  - Required: next edge gives mem_req=0, zw1_=1, all answers 1.
  - Stimulus: separately, dr_=dw_=0 in GRANT.
  - Required: no mem_req.

Source files
------------

// File: rtl/px_bus_iface.sv
// CPU-side system bus interface below the P-X state control: grants the bus,
// runs one request/ack memory transfer and pulses the rok_/ren_/rpe_ answer lines.
module px_bus_iface #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200,
   parameter logic [2:0] RESP_CYCLES    = 3'd3
) (
   input  logic        __clk,
   input  logic        clo,
   input  logic        zg,
   output logic        zw1_,
   input  logic        dr_,
   input  logic        dw_,
   input  logic [3:0]  nb,
   input  logic [15:0] ad,
   input  logic [15:0] dt_o,
   output logic [15:0] dt_i,
   output logic        rok_,
   output logic        ren_,
   output logic        rpe_,
   output logic        mem_req,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic        mem_perr,
   input  logic        mem_nomem
);

   typedef enum logic [2:0] {IDLE, GRANT, REQ, RESP, RELEASE} state_t;

   state_t     state, state_nx;
   logic [7:0] to_cnt;
   logic [2:0] rsp_cnt;
   logic       sel_ok, sel_en, sel_pe;
   logic       one_strobe, to_hit, rsp_last;

   assign one_strobe = dr_ ^ dw_;
   // Compares are widened so a count of 0 or 1 still gives a sane, non-wrapping limit.
   assign to_hit     = ({1'b0, to_cnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};
   assign rsp_last   = ({1'b0, rsp_cnt} + 4'd1) >= {1'b0, RESP_CYCLES};

   always_ff @(posedge __clk) begin
      if (clo) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      zw1_     = 1'b0;
      mem_req  = 1'b0;
      rok_     = 1'b1;
      ren_     = 1'b1;
      rpe_     = 1'b1;
      case (state)
         IDLE: begin
            zw1_ = 1'b1;
            if (zg) state_nx = GRANT;
         end
         GRANT: begin
            if (one_strobe)             state_nx = REQ;
            else if (dr_ && dw_ && !zg) state_nx = IDLE;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack)     state_nx = RESP;
            else if (to_hit) state_nx = RELEASE;
         end
         RESP: begin
            rok_ = ~sel_ok;
            ren_ = ~sel_en;
            rpe_ = ~sel_pe;
            if (rsp_last) state_nx = RELEASE;
         end
         RELEASE: begin
            if (!zg && dr_ && dw_) state_nx = IDLE;
         end
         default: begin
            zw1_     = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge __clk) begin
      if (clo) begin
         to_cnt    <= '0;
         rsp_cnt   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         dt_i      <= '0;
         sel_ok    <= 1'b0;
         sel_en    <= 1'b0;
         sel_pe    <= 1'b0;
      end else begin
         case (state)
            GRANT: begin
               if (one_strobe) begin
                  mem_addr  <= {nb, ad};
                  mem_wdata <= dt_o;
                  mem_we    <= ~dw_;
                  to_cnt    <= '0;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  // No-memory wins over parity; parity only reported on reads.
                  sel_ok  <= ~mem_nomem;
                  sel_en  <= mem_nomem;
                  sel_pe  <= ~mem_we & mem_perr & ~mem_nomem;
                  rsp_cnt <= '0;
                  mem_we  <= 1'b0;
                  if (!mem_we) dt_i <= mem_rdata;
               end else begin
                  if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                  if (to_hit) mem_we <= 1'b0;
               end
            end
            RESP: begin
               if (!rsp_last) rsp_cnt <= rsp_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
